claw_game_sequencer: RTL and testbench

//  Top-level game FSM for the claw machine. Counts credits, runs the joystick play window, then sequences drop/grab/lift/return/release.

---
 rtl/claw_pkg.sv | 33 +++
 rtl/claw_credit_ctr.sv | 41 ++++
 rtl/claw_game_sequencer.sv | 229 ++++++++++++++++++++++
 tb/tb_claw_game_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/claw_pkg.sv
// Shared types and constants for the claw machine game sequencer.
package claw_pkg;

   typedef enum logic [3:0] {
      IDLE,
      READY,
      MOVE,
      DROP,
      GRAB,
      LIFT,
      RETURN,
      RELEASE,
      FAULT
   } state_e;

   localparam logic [1:0] MOT_STOP = 2'b00;
   localparam logic [1:0] MOT_FWD  = 2'b01;
   localparam logic [1:0] MOT_REV  = 2'b10;

   localparam int unsigned ARM_CYCLES = 2;

   // Opposing buttons cancel, so 2'b11 can never reach a motor.
   function automatic logic [1:0] joy_cmd(input logic fwd, input logic rev);
      if (fwd && !rev) begin
         joy_cmd = MOT_FWD;
      end else if (rev && !fwd) begin
         joy_cmd = MOT_REV;
      end else begin
         joy_cmd = MOT_STOP;
      end
   endfunction

endpackage

// File: rtl/claw_credit_ctr.sv
// Saturating credit counter: +1 per inc, -1 per dec, inc and dec together cancel.
module claw_credit_ctr #(
   parameter int unsigned MAX_CREDITS = 9,
   parameter int unsigned CREDIT_W    = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                inc,
   input  logic                dec,
   output logic [CREDIT_W-1:0] count
);

   localparam logic [CREDIT_W-1:0] MAX_C = CREDIT_W'(MAX_CREDITS);

   logic [CREDIT_W-1:0] count_q;
   logic [CREDIT_W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (inc && !dec) begin
         if (count_q != MAX_C) begin
            count_d = count_q + 1'b1;
         end
      end else if (dec && !inc) begin
         if (count_q != '0) begin
            count_d = count_q - 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/claw_game_sequencer.sv
// Claw machine game FSM: credits, play window, drop/grab/lift/return/release.
// Optional build macro FREE_PLAY_EN: games start without credits and credits are never spent.
module claw_game_sequencer #(
   parameter int unsigned MAX_CREDITS = 9,
   parameter int unsigned CREDIT_W    = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                coin,
   input  logic                btn_l,
   input  logic                btn_r,
   input  logic                btn_f,
   input  logic                btn_b,
   input  logic                btn_go,
   input  logic                home_xy,
   input  logic                prize_sensor,
   input  logic                timeout1,
   input  logic                timeout2,
   output logic                en_t1,
   output logic                en_t2,
   output logic                r_tr,
   output logic [1:0]          motor_x,
   output logic [1:0]          motor_y,
   output logic [1:0]          motor_z,
   output logic                claw_close,
   output logic [CREDIT_W-1:0] credits,
   output logic                busy,
   output logic                prize_out,
   output logic                fault
);

   import claw_pkg::*;

`ifdef FREE_PLAY_EN
   localparam logic FREE_PLAY = 1'b1;
`else
   localparam logic FREE_PLAY = 1'b0;
`endif

   localparam logic [1:0] ARM_DONE = 2'(ARM_CYCLES);

   state_e     state_q, state_d;
   logic [1:0] arm_q, arm_d;
   logic       coin_q, go_q;
   logic       prize_done_q, prize_done_d;

   logic       en_t1_q, en_t1_d;
   logic       en_t2_q, en_t2_d;
   logic       r_tr_q, r_tr_d;
   logic [1:0] motor_x_q, motor_x_d;
   logic [1:0] motor_y_q, motor_y_d;
   logic [1:0] motor_z_q, motor_z_d;
   logic       claw_q, claw_d;
   logic       busy_q, busy_d;
   logic       prize_q, prize_d;
   logic       fault_q, fault_d;

   logic       coin_ev, go_ev;
   logic       credit_dec;
   logic       has_credit;
   logic       armed, arm_start;

   assign coin_ev    = coin && !coin_q;
   assign go_ev      = btn_go && !go_q;
   assign has_credit = (credits != '0);
   assign arm_start  = (arm_q == '0);
   assign armed      = (arm_q == ARM_DONE);

   claw_credit_ctr #(
      .MAX_CREDITS(MAX_CREDITS),
      .CREDIT_W   (CREDIT_W)
   ) u_credit_ctr (
      .clk  (clk),
      .rst  (rst),
      .inc  (coin_ev),
      .dec  (credit_dec),
      .count(credits)
   );

   always_comb begin
      state_d      = state_q;
      arm_d        = armed ? arm_q : arm_q + 2'd1;
      prize_done_d = prize_done_q;
      fault_d      = fault_q;
      credit_dec   = 1'b0;
      en_t1_d      = 1'b0;
      en_t2_d      = 1'b0;
      r_tr_d       = 1'b0;
      motor_x_d    = MOT_STOP;
      motor_y_d    = MOT_STOP;
      motor_z_d    = MOT_STOP;
      claw_d       = 1'b0;
      prize_d      = 1'b0;
      busy_d       = (state_q != IDLE) && (state_q != READY);

      case (state_q)
         IDLE: begin
            if (FREE_PLAY || has_credit) begin
               state_d = READY;
            end
         end
         READY: begin
            if (!FREE_PLAY && !has_credit) begin
               state_d = IDLE;
            end else if (go_ev) begin
               state_d      = MOVE;
               credit_dec   = !FREE_PLAY;
               prize_done_d = 1'b0;
            end
         end
         MOVE: begin
            // X: right is forward; Y: front is forward.
            motor_x_d = joy_cmd(btn_r, btn_l);
            motor_y_d = joy_cmd(btn_f, btn_b);
            r_tr_d    = arm_start;
            en_t1_d   = armed;
            if (go_ev || (armed && timeout1)) begin
               state_d = DROP;
            end
         end
         DROP: begin
            motor_z_d = MOT_FWD;
            r_tr_d    = arm_start;
            en_t2_d   = armed;
            if (armed && timeout2) begin
               state_d = GRAB;
            end
         end
         GRAB: begin
            claw_d  = 1'b1;
            r_tr_d  = arm_start;
            en_t2_d = armed;
            if (armed && timeout2) begin
               state_d = LIFT;
            end
         end
         LIFT: begin
            motor_z_d = MOT_REV;
            claw_d    = 1'b1;
            r_tr_d    = arm_start;
            en_t2_d   = armed;
            if (armed && timeout2) begin
               state_d = RETURN;
            end
         end
         RETURN: begin
            motor_x_d = home_xy ? MOT_STOP : MOT_REV;
            motor_y_d = home_xy ? MOT_STOP : MOT_REV;
            claw_d    = 1'b1;
            r_tr_d    = arm_start;
            en_t1_d   = armed;
            if (home_xy) begin
               state_d = RELEASE;
            end else if (armed && timeout1) begin
               state_d = FAULT;
            end
         end
         RELEASE: begin
            r_tr_d  = arm_start;
            en_t2_d = armed;
            if (prize_sensor && !prize_done_q) begin
               prize_d      = 1'b1;
               prize_done_d = 1'b1;
            end
            if (armed && timeout2) begin
               state_d = (FREE_PLAY || has_credit) ? READY : IDLE;
            end
         end
         FAULT: begin
            fault_d = 1'b1;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (state_d != state_q) begin
         arm_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         arm_q        <= '0;
         coin_q       <= 1'b0;
         go_q         <= 1'b0;
         prize_done_q <= 1'b0;
         en_t1_q      <= 1'b0;
         en_t2_q      <= 1'b0;
         r_tr_q       <= 1'b0;
         motor_x_q    <= MOT_STOP;
         motor_y_q    <= MOT_STOP;
         motor_z_q    <= MOT_STOP;
         claw_q       <= 1'b0;
         busy_q       <= 1'b0;
         prize_q      <= 1'b0;
         fault_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         arm_q        <= arm_d;
         coin_q       <= coin;
         go_q         <= btn_go;
         prize_done_q <= prize_done_d;
         en_t1_q      <= en_t1_d;
         en_t2_q      <= en_t2_d;
         r_tr_q       <= r_tr_d;
         motor_x_q    <= motor_x_d;
         motor_y_q    <= motor_y_d;
         motor_z_q    <= motor_z_d;
         claw_q       <= claw_d;
         busy_q       <= busy_d;
         prize_q      <= prize_d;
         fault_q      <= fault_d;
      end
   end

   assign en_t1      = en_t1_q;
   assign en_t2      = en_t2_q;
   assign r_tr       = r_tr_q;
   assign motor_x    = motor_x_q;
   assign motor_y    = motor_y_q;
   assign motor_z    = motor_z_q;
   assign claw_close = claw_q;
   assign busy       = busy_q;
   assign prize_out  = prize_q;
   assign fault      = fault_q;

endmodule

// File: tb/tb_claw_game_sequencer.sv
// Scoreboard bench for claw_game_sequencer: per-cycle reference model feeds an expectation queue.
module tb_claw_game_sequencer;

   logic       clk = 1'b0;
   logic       rst, coin, btn_l, btn_r, btn_f, btn_b, btn_go, home_xy, prize_sensor;
   logic       timeout1, timeout2;
   logic       en_t1, en_t2, r_tr, claw_close, busy, prize_out, fault;
   logic [1:0] motor_x, motor_y, motor_z;
   logic [3:0] credits;

   always #5 clk = ~clk;

   claw_game_sequencer #(
      .MAX_CREDITS(9),
      .CREDIT_W   (4)
   ) dut (
      .clk(clk), .rst(rst), .coin(coin),
      .btn_l(btn_l), .btn_r(btn_r), .btn_f(btn_f), .btn_b(btn_b), .btn_go(btn_go),
      .home_xy(home_xy), .prize_sensor(prize_sensor),
      .timeout1(timeout1), .timeout2(timeout2),
      .en_t1(en_t1), .en_t2(en_t2), .r_tr(r_tr),
      .motor_x(motor_x), .motor_y(motor_y), .motor_z(motor_z),
      .claw_close(claw_close), .credits(credits), .busy(busy),
      .prize_out(prize_out), .fault(fault)
   );

   // Environment timers driven by the DUT's own timer controls.
   int unsigned t1_cnt = 0, t2_cnt = 0, t1_limit = 12;
   always @(posedge clk) begin
      if (r_tr === 1'b1) begin
         t1_cnt <= 0;
         t2_cnt <= 0;
      end else begin
         if (en_t1 === 1'b1) t1_cnt <= t1_cnt + 1;
         if (en_t2 === 1'b1) t2_cnt <= t2_cnt + 1;
      end
   end
   assign timeout1 = (t1_cnt >= t1_limit);
   assign timeout2 = (t2_cnt >= 2);

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int         cyc;
      logic       r_tr, en1, en2, claw, busy, prize, fault;
      logic [1:0] mx, my, mz;
      logic [3:0] cred;
   } exp_t;
   exp_t q[$];

   int n_asrt = 0, n_fail = 0, prize_seen = 0;

   task automatic chk(input string nm, input logic [3:0] got, input logic [3:0] ex);
      n_asrt++;
      if (got !== ex) begin
         n_fail++;
         $display("FAIL %s cyc %0d got %0h expected %0h", nm, cyc, got, ex);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (prize_out === 1'b1) prize_seen++;
      if (q.size() > 0 && q[0].cyc <= cyc) begin
         e = q.pop_front();
         chk("r_tr", {3'b0, r_tr}, {3'b0, e.r_tr});
         chk("en_t1", {3'b0, en_t1}, {3'b0, e.en1});
         chk("en_t2", {3'b0, en_t2}, {3'b0, e.en2});
         chk("motor_x", {2'b0, motor_x}, {2'b0, e.mx});
         chk("motor_y", {2'b0, motor_y}, {2'b0, e.my});
         chk("motor_z", {2'b0, motor_z}, {2'b0, e.mz});
         chk("claw_close", {3'b0, claw_close}, {3'b0, e.claw});
         chk("credits", credits, e.cred);
         chk("busy", {3'b0, busy}, {3'b0, e.busy});
         chk("prize_out", {3'b0, prize_out}, {3'b0, e.prize});
         chk("fault", {3'b0, fault}, {3'b0, e.fault});
      end
   end

   // Reference model: game phase by name, age = cycles spent in the phase.
`ifdef FREE_PLAY_EN
   localparam bit FREE = 1'b1;
`else
   localparam bit FREE = 1'b0;
`endif
   string m_ph = "IDLE";
   int    m_age = 0, m_cred = 0;
   bit    m_prize_done = 0, m_fault = 0, m_coin_p = 0, m_go_p = 0;

   function automatic logic [1:0] joy(input logic f, input logic r);
      if (f == r) return 2'd0;
      return f ? 2'd1 : 2'd2;
   endfunction

   task automatic model_step();
      exp_t  e;
      string nxt;
      bit    coin_ev, go_ev, live, dec;
      e = '{cyc: cyc + 1, default: '0};
      if (rst) begin
         m_ph = "IDLE"; m_age = 0; m_cred = 0;
         m_prize_done = 0; m_fault = 0; m_coin_p = 0; m_go_p = 0;
         q.push_back(e);
         return;
      end
      coin_ev = coin && !m_coin_p;
      go_ev   = btn_go && !m_go_p;
      live    = (m_age >= 2);
      dec     = 0;
      nxt     = m_ph;
      e.busy  = !(m_ph == "IDLE" || m_ph == "READY");
      if (m_ph == "IDLE") begin
         if (FREE || m_cred > 0) nxt = "READY";
      end else if (m_ph == "READY") begin
         if (!FREE && m_cred == 0) nxt = "IDLE";
         else if (go_ev) begin
            nxt = "MOVE"; dec = !FREE; m_prize_done = 0;
         end
      end else if (m_ph == "MOVE") begin
         e.mx = joy(btn_r, btn_l); e.my = joy(btn_f, btn_b);
         e.r_tr = (m_age == 0); e.en1 = live;
         if (go_ev || (live && timeout1)) nxt = "DROP";
      end else if (m_ph == "DROP" || m_ph == "GRAB" || m_ph == "LIFT") begin
         e.r_tr = (m_age == 0); e.en2 = live;
         if (m_ph == "DROP") e.mz = 2'd1;
         if (m_ph == "LIFT") e.mz = 2'd2;
         e.claw = (m_ph != "DROP");
         if (live && timeout2) nxt = (m_ph == "DROP") ? "GRAB" : (m_ph == "GRAB") ? "LIFT" : "RETURN";
      end else if (m_ph == "RETURN") begin
         e.mx = home_xy ? 2'd0 : 2'd2; e.my = e.mx; e.claw = 1;
         e.r_tr = (m_age == 0); e.en1 = live;
         if (home_xy) nxt = "RELEASE";
         else if (live && timeout1) nxt = "FAULT";
      end else if (m_ph == "RELEASE") begin
         e.r_tr = (m_age == 0); e.en2 = live;
         if (prize_sensor && !m_prize_done) begin
            e.prize = 1; m_prize_done = 1;
         end
         if (live && timeout2) nxt = (FREE || m_cred > 0) ? "READY" : "IDLE";
      end else if (m_ph == "FAULT") begin
         m_fault = 1;
      end
      m_cred = m_cred + int'(coin_ev) - int'(dec);
      if (m_cred > 9) m_cred = 9;
      e.cred  = 4'(m_cred);
      e.fault = m_fault;
      m_age   = (nxt != m_ph) ? 0 : m_age + 1;
      m_ph    = nxt;
      m_coin_p = coin;
      m_go_p   = btn_go;
      q.push_back(e);
   endtask

   task automatic step();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic fail_now(input string nm);
      n_asrt++;
      n_fail++;
      $display("FAIL %s cyc %0d got phase %s", nm, cyc, m_ph);
   endtask

   // Game shaping knobs.
   int    g_go_mode = 0, g_go_after = 0, g_home_mode = 0, g_home_delay = 5;
   int    g_prize_start = 2, g_prize_len = 3;
   bit    g_fixed_joy = 0, g_rand_coin = 0;
   string g_stop = "";

   task automatic play_game(input bit press);
      bit seen_move = 0;
      if (press) begin
         for (int i = 0; i < 10 && m_ph != "READY"; i++) step();
         if (m_ph != "READY") begin
            fail_now("reach_ready");
            return;
         end
         btn_go = 1;
         step();
      end
      for (int i = 0; i < 400; i++) begin
         if (m_ph == "MOVE") seen_move = 1;
         if (g_stop != "" && m_ph == g_stop) return;
         if (seen_move && (m_ph == "IDLE" || m_ph == "READY" || m_ph == "FAULT")) begin
            coin = 0;
            return;
         end
         btn_go = 0; home_xy = 0; prize_sensor = 0;
         btn_l = 0; btn_r = 0; btn_f = 0; btn_b = 0;
         coin = g_rand_coin ? ($urandom_range(0, 7) == 0) : 1'b0;
         if (m_ph == "MOVE") begin
            if (g_fixed_joy) begin
               btn_l = 1; btn_r = 1; btn_f = 1;
            end else begin
               {btn_l, btn_r, btn_f, btn_b} = 4'($urandom);
            end
            if (g_go_mode == 1) btn_go = (m_age == g_go_after);
            if (g_go_mode == 2) btn_go = (m_age >= 2) && timeout1;
         end else if (m_ph == "RETURN") begin
            if (g_home_mode == 0) home_xy = (m_age >= g_home_delay);
            if (g_home_mode == 2) home_xy = (m_age >= 2) && timeout1;
         end else if (m_ph == "RELEASE") begin
            home_xy = 1;
            prize_sensor = (m_age >= g_prize_start) && (m_age < g_prize_start + g_prize_len);
         end
         step();
      end
      fail_now("game_budget");
   endtask

   task automatic do_reset(input int n);
      rst = 1;
      repeat (n) step();
      rst = 0;
   endtask

   task automatic pulse_coin();
      coin = 1; step();
      coin = 0; step();
   endtask

   initial begin
      rst = 1; coin = 0; btn_l = 0; btn_r = 0; btn_f = 0; btn_b = 0;
      btn_go = 0; home_xy = 0; prize_sensor = 0;
      do_reset(2);
      step();

      // One credit, fixed joystick, play window expires, prize sensed for 3 cycles.
      pulse_coin();
      g_fixed_joy = 1;
      prize_seen = 0;
      play_game(1);
      repeat (3) step();
      chk("prize_pulses", 4'(prize_seen), 4'd1);
      g_fixed_joy = 0;

      // Two credits: first game ends in READY, second dropped early by the button.
      pulse_coin(); pulse_coin();
      play_game(1);
      g_go_mode = 1; g_go_after = 4;
      play_game(1);
      g_go_after = 1;
      pulse_coin();
      play_game(1);
      g_go_mode = 0;

      // Saturation, then coin and go in the same cycle.
      repeat (12) pulse_coin();
      for (int i = 0; i < 10 && m_ph != "READY"; i++) step();
      coin = 1; btn_go = 1; step();
      coin = 0; btn_go = 0;
      g_go_mode = 2; g_home_mode = 2;
      play_game(0);
      g_go_mode = 0; g_home_mode = 0;
      do_reset(1);

      // Watchdog fault, coins still counted, exit only by reset.
      pulse_coin();
      g_home_mode = 1;
      play_game(1);
      g_home_mode = 0;
      repeat (3) pulse_coin();
      repeat (5) step();
      do_reset(1);
      repeat (3) step();

      // Reset in the middle of LIFT.
      pulse_coin();
      g_stop = "LIFT";
      play_game(1);
      step(); step();
      g_stop = "";
      do_reset(1);
      repeat (4) step();

      // Randomised games.
      g_rand_coin = 1;
      for (int k = 0; k < 25; k++) begin
         t1_limit      = $urandom_range(6, 20);
         g_go_mode     = $urandom_range(0, 2);
         g_go_after    = $urandom_range(0, 6);
         g_home_mode   = ($urandom_range(0, 9) == 0) ? 1 : $urandom_range(0, 1) * 2;
         g_home_delay  = $urandom_range(0, 5);
         g_prize_start = $urandom_range(0, 4);
         g_prize_len   = $urandom_range(0, 4);
         if (m_ph == "FAULT") do_reset(1);
         if (!FREE && m_cred == 0) pulse_coin();
         play_game(1);
         repeat ($urandom_range(0, 3)) step();
      end
      g_rand_coin = 0; coin = 0;
      repeat (3) step();
      @(negedge clk);
      #1;
      n_asrt++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL queue_drain got %0d entries expected 0", q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end

endmodule
